// File: rtl/pc_unit.sv
// IF-stage fetch-address register: next-PC selection with exception entry, ERET,
// a one-entry pending-redirect buffer for redirects raised under stall, and a fetch fault flag.
module pc_unit #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(32'h0000_3000),
    parameter logic [WIDTH-1:0] EXC_VEC   = WIDTH'(32'h0000_4180),
    parameter logic [WIDTH-1:0] IMEM_LO   = WIDTH'(32'h0000_3000),
    parameter logic [WIDTH-1:0] IMEM_HI   = WIDTH'(32'h0000_6FFC)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             redir_valid,
    input  logic [WIDTH-1:0] redir_target,
    input  logic             exc_req,
    input  logic             eret_req,
    input  logic [WIDTH-1:0] epc,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus4,
    output logic             pend_valid,
    output logic             fetch_exc
);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] pend_target_q, pend_target_d;
    logic             pend_valid_q, pend_valid_d;

    assign pc_plus4 = pc_q + WIDTH'(4);

    always_comb begin
        // NOTE: every next-state value gets a default first so no branch can leave it unassigned (no latches).
        pc_d          = pc_plus4;
        pend_valid_d  = pend_valid_q;
        pend_target_d = pend_target_q;

        if (exc_req) begin
            pc_d         = EXC_VEC;
            pend_valid_d = 1'b0;
        end else if (eret_req) begin
            pc_d         = epc;
            pend_valid_d = 1'b0;
        end else if (stall) begin
            pc_d = pc_q;
            // A newer redirect simply replaces whatever was parked.
            if (redir_valid) begin
                pend_target_d = redir_target;
                pend_valid_d  = 1'b1;
            end
        end else if (redir_valid) begin
            pc_d         = redir_target;
            pend_valid_d = 1'b0;
        end else if (pend_valid_q) begin
            pc_d         = pend_target_q;
            pend_valid_d = 1'b0;
        end
    end

    // NOTE: state is updated with non-blocking assignments so all flops sample pre-edge values together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q          <= RESET_VEC;
            pend_valid_q  <= 1'b0;
            pend_target_q <= '0;
        end else begin
            pc_q          <= pc_d;
            pend_valid_q  <= pend_valid_d;
            pend_target_q <= pend_target_d;
        end
    end

    assign pc         = pc_q;
    assign pend_valid = pend_valid_q;
    assign fetch_exc  = (pc_q[1:0] != 2'b00) || (pc_q < IMEM_LO) || (pc_q > IMEM_HI);

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed cases plus randomized traffic
// compared against a queue-based reference of the next-PC rules.
module tb_pc_unit;

    localparam logic [31:0] RST_V = 32'h0000_3000;
    localparam logic [31:0] EXC_V = 32'h0000_4180;
    localparam logic [31:0] LO_V  = 32'h0000_3000;
    localparam logic [31:0] HI_V  = 32'h0000_6FFC;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall, redir_valid, exc_req, eret_req;
    logic [31:0] redir_target, epc;
    logic [31:0] pc, pc_plus4;
    logic        pend_valid, fetch_exc;

    logic [15:0] zero16 = 16'h0000;
    logic [15:0] pc16, pc_plus4_16;
    logic        pend_valid16, fetch_exc16;

    int n_cmp = 0;
    int n_err = 0;

    // Reference state: the pending redirect is a queue holding at most one target.
    logic [31:0] m_pc;
    logic [31:0] m_pend[$];

    always #5 clk = ~clk;

    pc_unit dut (
        .clk(clk), .reset(reset), .stall(stall), .redir_valid(redir_valid),
        .redir_target(redir_target), .exc_req(exc_req), .eret_req(eret_req), .epc(epc),
        .pc(pc), .pc_plus4(pc_plus4), .pend_valid(pend_valid), .fetch_exc(fetch_exc)
    );

    pc_unit #(
        .WIDTH(16), .RESET_VEC(16'hFFFC), .EXC_VEC(16'h0180),
        .IMEM_LO(16'h0000), .IMEM_HI(16'hFFFC)
    ) dut16 (
        .clk(clk), .reset(reset), .stall(1'b0), .redir_valid(1'b0),
        .redir_target(zero16), .exc_req(1'b0), .eret_req(1'b0), .epc(zero16),
        .pc(pc16), .pc_plus4(pc_plus4_16), .pend_valid(pend_valid16), .fetch_exc(fetch_exc16)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_fault(input logic [31:0] a);
        return (a % 4 != 0) || (a < LO_V) || (a > HI_V);
    endfunction

    task automatic check_all(input string tag);
        check({tag, ".pc"}, pc, m_pc);
        check({tag, ".pend"}, {31'd0, pend_valid}, {31'd0, m_pend.size() != 0});
        check({tag, ".plus4"}, pc_plus4, m_pc + 32'd4);
        check({tag, ".fexc"}, {31'd0, fetch_exc}, {31'd0, exp_fault(m_pc)});
    endtask

    task automatic model_edge();
        if (exc_req) begin
            m_pc = EXC_V;
            m_pend.delete();
        end else if (eret_req) begin
            m_pc = epc;
            m_pend.delete();
        end else if (stall) begin
            if (redir_valid) begin
                m_pend.delete();
                m_pend.push_back(redir_target);
            end
        end else if (redir_valid) begin
            m_pc = redir_target;
            m_pend.delete();
        end else if (m_pend.size() != 0) begin
            m_pc = m_pend.pop_front();
        end else begin
            m_pc = m_pc + 32'd4;
        end
    endtask

    // Drive one cycle's inputs, confirm pc does not react before the edge, then check after it.
    task automatic step(input string tag, input logic s, input logic rv, input logic [31:0] tgt,
                        input logic ex, input logic er, input logic [31:0] ep);
        stall = s; redir_valid = rv; redir_target = tgt;
        exc_req = ex; eret_req = er; epc = ep;
        #1;
        check({tag, ".pre"}, pc, m_pc);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    endtask

    task automatic redir(input string tag, input logic [31:0] tgt);
        step(tag, 1'b0, 1'b1, tgt, 1'b0, 1'b0, 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        stall = 1'b0; redir_valid = 1'b0; exc_req = 1'b0; eret_req = 1'b0;
        redir_target = '0; epc = '0;
        m_pc = RST_V;
        m_pend.delete();
        #2;
        check_all("reset");
        check("w16.reset_pc", {16'd0, pc16}, 32'h0000_FFFC);
        check("w16.reset_plus4", {16'd0, pc_plus4_16}, 32'h0000_0000);
        check("w16.reset_pend", {31'd0, pend_valid16}, 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        @(posedge clk);
        #1;
        check("w16.wrap_pc", {16'd0, pc16}, 32'h0000_0000);
        check("w16.wrap_fexc", {31'd0, fetch_exc16}, 32'd0);
        m_pc = m_pc + 32'd4;
        check_all("seq1");
        idle("seq2");
        idle("seq3");
        idle("seq4");

        // Redirect raised under stall is parked, then applied on the first free edge.
        step("stall_rv", 1'b1, 1'b1, 32'h3100, 1'b0, 1'b0, 32'd0);
        check("stall_rv.pc_const", pc, 32'h3010);
        step("stall2", 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        step("stall3", 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        idle("pend_apply");
        check("pend_apply.pc_const", pc, 32'h3100);
        idle("pend_next");

        // Every request at once, with a redirect already pending: exception wins.
        step("park", 1'b1, 1'b1, 32'h3300, 1'b0, 1'b0, 32'd0);
        step("prio", 1'b1, 1'b1, 32'h3200, 1'b1, 1'b1, 32'h3020);
        check("prio.pc_const", pc, 32'h4180);
        step("eret", 1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 32'h3044);
        check("eret.pc_const", pc, 32'h3044);

        // Live redirect beats a pending one.
        step("park2", 1'b1, 1'b1, 32'h3500, 1'b0, 1'b0, 32'd0);
        redir("live_beats", 32'h3600);
        idle("after_live");

        redir("flt_misalign", 32'h3002);
        redir("flt_low", 32'h2FFC);
        redir("flt_high", 32'h7000);
        redir("ok_top", 32'h6FFC);
        idle("top_plus4");
        redir("wrap_set", 32'hFFFF_FFFC);
        idle("wrap32");

        // Asynchronous reset mid-stall with a pending redirect, between edges.
        step("park3", 1'b1, 1'b1, 32'h3800, 1'b0, 1'b0, 32'd0);
        #3 reset = 1'b1;
        #1;
        m_pc = RST_V;
        m_pend.delete();
        check_all("async_rst");
        #2 reset = 1'b0;
        idle("post_rst");

        for (int i = 0; i < 400; i++) begin
            logic [31:0] tgt;
            tgt = ($urandom % 8 == 0) ? $urandom : LO_V + 32'(($urandom % 32'h1000) * 4);
            step("rand", ($urandom % 3) == 0, ($urandom % 4) == 0, tgt,
                 ($urandom % 20) == 0, ($urandom % 20) == 0, LO_V + 32'(($urandom % 32'h1000) * 4));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
